// File: rtl/bcd_display_scheduler.sv
// Round-robin scheduler sharing one binary-to-BCD stage and one 7-segment decoder
// across NCH requesters. Optional macro: BLANK_LEADING_ZERO_EN (blank a zero tens digit).
module bcd_display_scheduler #(
  parameter int unsigned NCH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     req,
  input  logic [4*NCH-1:0]   val,
  output logic [NCH-1:0]     ack,
  output logic [7*NCH-1:0]   hex_ones,
  output logic [7*NCH-1:0]   hex_tens,
  output logic               busy
);

  localparam int unsigned PW        = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, CONV, WRITE} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   g_r;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   scan_idx;
  logic            grant_found;
  logic [3:0]      v_r;
  logic [3:0]      ones_r;
  logic            tens_r;
  logic [6:0]      tens_seg;
  logic [3:0]      val_a   [NCH];
  logic [6:0]      ones_q  [NCH];
  logic [6:0]      tens_q  [NCH];

  // Active-low segments, bit order gfedcba.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign val_a[i]            = val[4*i +: 4];
    assign hex_ones[7*i +: 7]  = ones_q[i];
    assign hex_tens[7*i +: 7]  = tens_q[i];
  end

  // First requester at or after ptr, wrapping modulo NCH.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      scan_idx = PW'((32'(ptr) + i) % NCH);
      if (!grant_found && req[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

`ifdef BLANK_LEADING_ZERO_EN
  assign tens_seg = tens_r ? seg7(4'd1) : SEG_BLANK;
`else
  assign tens_seg = seg7({3'b000, tens_r});
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_found) state_nx = CONV;
      CONV:    state_nx = WRITE;
      WRITE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      g_r    <= '0;
      v_r    <= '0;
      ones_r <= '0;
      tens_r <= 1'b0;
      ack    <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        ones_q[i] <= SEG_BLANK;
        tens_q[i] <= SEG_BLANK;
      end
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            v_r <= val_a[grant_idx];
            g_r <= grant_idx;
          end
        end
        CONV: begin
          if (v_r > 4'd9) begin
            ones_r <= v_r - 4'd10;
            tens_r <= 1'b1;
          end else begin
            ones_r <= v_r;
            tens_r <= 1'b0;
          end
        end
        WRITE: begin
          for (int unsigned i = 0; i < NCH; i++) begin
            if (PW'(i) == g_r) begin
              ones_q[i] <= seg7(ones_r);
              tens_q[i] <= tens_seg;
              ack[i]    <= 1'b1;
            end
          end
          // Folds to a constant 0 when NCH == 1.
          ptr <= (g_r == PW'(NCH - 1)) ? '0 : g_r + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Directed, table-driven bench for bcd_display_scheduler (NCH = 4).
module tb_bcd_display_scheduler;

  localparam int unsigned NCH = 4;
  localparam logic [6:0]  BL  = 7'h7F;
`ifdef BLANK_LEADING_ZERO_EN
  localparam logic [6:0]  TZ  = 7'h7F;
`else
  localparam logic [6:0]  TZ  = 7'h40;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NCH-1:0]     req = '0;
  logic [4*NCH-1:0]   val = '0;
  logic [NCH-1:0]     ack;
  logic [7*NCH-1:0]   hex_ones;
  logic [7*NCH-1:0]   hex_tens;
  logic               busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7*NCH-1:0] exp_ones;
  logic [7*NCH-1:0] exp_tens;

  typedef struct {
    int         ch;
    logic [3:0] v;
    logic [6:0] ones;
    logic [6:0] tens;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  bcd_display_scheduler #(.NCH(NCH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .val      (val),
    .ack      (ack),
    .hex_ones (hex_ones),
    .hex_tens (hex_tens),
    .busy     (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One isolated request; req and val are disturbed right after the grant edge.
  task automatic run_vec(input vec_t t);
    @(negedge clk);
    req[t.ch] = 1'b1;
    val[4*t.ch +: 4] = t.v;
    @(posedge clk);
    #1;
    req[t.ch] = 1'b0;
    val[4*t.ch +: 4] = ~t.v;
    exp_ones[7*t.ch +: 7] = t.ones;
    exp_tens[7*t.ch +: 7] = t.tens;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 3) begin
        chk("busy_inflight", 32'(busy), 32'd1);
        chk("ack_early", 32'(ack), 32'd0);
      end else if (c == 3) begin
        chk("ack_pulse", 32'(ack), 32'd1 << t.ch);
        chk("busy_done", 32'(busy), 32'd0);
        chk("hex_ones", 32'(hex_ones), 32'(exp_ones));
        chk("hex_tens", 32'(hex_tens), 32'(exp_tens));
      end else begin
        chk("ack_clear", 32'(ack), 32'd0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t t;
    vecs[0] = '{0, 4'd7,  7'h78, TZ};
    vecs[1] = '{2, 4'd15, 7'h12, 7'h79};
    vecs[2] = '{2, 4'd9,  7'h10, TZ};
    vecs[3] = '{1, 4'd10, 7'h40, 7'h79};
    vecs[4] = '{3, 4'd0,  7'h40, TZ};
    vecs[5] = '{3, 4'd12, 7'h24, 7'h79};
    vecs[6] = '{1, 4'd3,  7'h30, TZ};
    vecs[7] = '{0, 4'd4,  7'h19, TZ};
    exp_ones = '1;
    exp_tens = '1;

    // Reset, then idle with no requests.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_hex_ones", 32'(hex_ones), 32'(exp_ones));
      chk("rst_hex_tens", 32'(hex_tens), 32'(exp_tens));
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // All channels held from reset release: grants 0,1,2,3 then wrap to 0.
    @(negedge clk);
    rst = 1'b1;
    req = '1;
    val = {4'd12, 4'd0, 4'd10, 4'd9};
    exp_ones = '1;
    exp_tens = '1;
    @(negedge clk);
    chk("rr_rst_ack", 32'(ack), 32'd0);
    chk("rr_rst_hex", 32'(hex_ones), 32'(exp_ones));
    rst = 1'b0;
    exp_ones = {7'h24, 7'h40, 7'h40, 7'h10};
    exp_tens = {7'h79, TZ, 7'h79, TZ};
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      chk("rr_ack", 32'(ack), (c % 3 == 0) ? (32'd1 << ((c / 3 - 1) % 4)) : 32'd0);
    end
    req = '0;
    chk("rr_hex_ones", 32'(hex_ones), 32'(exp_ones));
    chk("rr_hex_tens", 32'(hex_tens), 32'(exp_tens));
    @(negedge clk);
    chk("rr_idle_busy", 32'(busy), 32'd0);

    // Leave ptr at 3 so a stale pointer would favour ch3 after the abort.
    t = '{2, 4'd6, 7'h02, TZ};
    run_vec(t);

    // Reset during CONV aborts; afterwards ch1 must win over ch3 from ptr=0.
    @(negedge clk);
    req[1] = 1'b1;
    val[7:4] = 4'd11;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    exp_ones = '1;
    exp_tens = '1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_hex_ones", 32'(hex_ones), 32'(exp_ones));
    chk("abort_hex_tens", 32'(hex_tens), 32'(exp_tens));
    @(negedge clk);
    chk("abort_ack_held", 32'(ack), 32'd0);
    rst = 1'b0;
    req = 4'b1010;
    val[15:12] = 4'd5;
    exp_ones[13:7] = 7'h79;
    exp_tens[13:7] = 7'h79;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c < 3) chk("post_abort_ack_early", 32'(ack), 32'd0);
      else       chk("post_abort_ack", 32'(ack), 32'b0010);
    end
    req = '0;
    chk("post_abort_hex_ones", 32'(hex_ones), 32'(exp_ones));
    chk("post_abort_hex_tens", 32'(hex_tens), 32'(exp_tens));
    @(negedge clk);
    chk("post_abort_ack_clear", 32'(ack), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
